score_bcd_digitizer: RTL and testbench
======================================

// Module: score_bcd_digitizer
// PURPOSE
//  Producer side of the on-screen digit display: converts a binary score/speed value into nine
//  BCD digit codes (digit1..digit9) plus a per-digit visibility mask for the number bitmap renderer.
//  Sequential double-dabble, one input bit per clock. Outputs hold the last result during conversion.
//  Sits between game logic (score/distance counters) and the digit-drawing path.
// PARAMETERS
//  IN_WIDTH      30          width of binValue; 2^30-1 covers all 9-digit values
//  SAT_VALUE     999999999   inputs above this are clamped to this before conversion
//  BLANK_LEADING 1           1: leading-zero digits masked invisible; 0: digitVisible all ones
// PORTS
//  clk           in   1         system clock
//  resetN        in   1         asynchronous active-low reset
//  startConv     in   1         request conversion; sampled only in IDLE
//  binValue      in   IN_WIDTH  binary value; captured on the edge that accepts startConv
//  busy          out  1         1 while state != IDLE (combinational from state register)
//  done          out  1         one-cycle pulse: new digits valid
//  digit1..9     out  4 each    BCD codes 0..9; digit1 = least significant, digit9 = most
//  digitVisible  out  9         bit i-1 = draw digit i
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, shift/BCD regs=0, bit counter=0, digit1..9=0,
//   done=0, digitVisible=9'b000000001.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: if startConv=1 at edge k: bin_reg <= min(binValue, SAT_VALUE); bcd_reg(36b) <= 0;
//    cnt <= 0; -> SHIFT. Else stay.
//   SHIFT: each edge (k+1..k+IN_WIDTH): every BCD nibble >= 5 gets +3 (all nibbles corrected in
//    parallel, 4-bit add, no carry between nibbles), then {bcd_reg,bin_reg} shifts left 1.
//    cnt increments; on the edge where cnt == IN_WIDTH-1 -> DONE.
//   DONE: edge k+IN_WIDTH+1: digit1..9 <= bcd nibbles, digitVisible updated, done <= 1 (high for
//    exactly that one cycle), -> IDLE.
//  Latency: start accepted at edge k -> outputs/done valid after edge k+31 (IN_WIDTH=30).
//  startConv while busy (SHIFT or DONE) is ignored, not queued. startConv held high continuously:
//   next accept at edge k+32, i.e. one conversion per 32 cycles.
//  binValue may change after the accepting edge without effect.
//  digit outputs and digitVisible change only on the DONE edge; never show partial results.
//  digitVisible (BLANK_LEADING=1): bit0 always 1; bit i (i>=1) = 1 iff digit(i+1) or any more
//   significant digit is non-zero. Value 0 -> 9'b000000001.
//  Saturation: comparison on full IN_WIDTH unsigned value; SAT_VALUE itself is not clamped.
//  Any nibble ever >9 on output is a design error (assertion in bench).
//  Reset mid-conversion aborts; no done pulse; outputs return to reset values.
// TESTING
//  binValue=0, start -> after 31 cycles done=1 once, all digits 0, digitVisible=9'h001.
//  binValue=1234 -> digit1..4 = 4,3,2,1, digit5..9 = 0, digitVisible=9'h00F, busy low after done.
//  binValue=999999999 -> all nine digits = 9, digitVisible=9'h1FF; binValue=2^30-1 -> same (clamped).
//  Start 1234, pulse start with 5678 at cycle 10 -> ignored; result 1234, only one done pulse;
//   old digits unchanged until done edge.
//  Start 50, assert resetN=0 at cycle 15 -> immediate IDLE, digits 0, no done; new start 50 -> digits 0,5.
//  Held startConv with values 7 then 80 -> done pulses 32 cycles apart, digits 7 then 0,8.

Source files
------------

// File: rtl/score_bcd_digitizer.sv
// Sequential double-dabble converter: clamps a binary score to nine decimal digits and
// produces BCD digit codes plus a leading-zero visibility mask for the digit renderer.
module score_bcd_digitizer #(
    parameter int          IN_WIDTH      = 30,
    parameter int unsigned SAT_VALUE     = 999999999,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                startConv,
    input  logic [IN_WIDTH-1:0] binValue,
    output logic                busy,
    output logic                done,
    output logic [3:0]          digit1,
    output logic [3:0]          digit2,
    output logic [3:0]          digit3,
    output logic [3:0]          digit4,
    output logic [3:0]          digit5,
    output logic [3:0]          digit6,
    output logic [3:0]          digit7,
    output logic [3:0]          digit8,
    output logic [3:0]          digit9,
    output logic [8:0]          digitVisible
);

    localparam int                  CNT_W    = $clog2(IN_WIDTH);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(IN_WIDTH - 1);
    localparam logic [IN_WIDTH-1:0] SAT_VEC  = IN_WIDTH'(SAT_VALUE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [IN_WIDTH-1:0] bin_q,    bin_d;
    logic [35:0]         bcd_q,    bcd_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [35:0]         digits_q, digits_d;
    logic [8:0]          vis_q,    vis_d;
    logic                done_q,   done_d;

    logic [35:0]         bcd_adj;
    logic [8:0]          vis_calc;

    // Every nibble is corrected independently; no carry crosses nibble boundaries.
    for (genvar gi = 0; gi < 9; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? (bcd_q[4*gi +: 4] + 4'd3)
                                                               : bcd_q[4*gi +: 4];
    end

    // Digit i+1 is visible when it or any more significant digit is non-zero.
    assign vis_calc[0] = 1'b1;
    for (genvar gi = 1; gi < 9; gi++) begin : g_vis
        assign vis_calc[gi] = BLANK_LEADING ? (|bcd_q[35:4*gi]) : 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        vis_d    = vis_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (startConv) begin
                    bin_d   = (binValue > SAT_VEC) ? SAT_VEC : binValue;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                digits_d = bcd_q;
                vis_d    = vis_calc;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            vis_q    <= 9'h001;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            vis_q    <= vis_d;
            done_q   <= done_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign digitVisible = vis_q;
    assign digit1       = digits_q[3:0];
    assign digit2       = digits_q[7:4];
    assign digit3       = digits_q[11:8];
    assign digit4       = digits_q[15:12];
    assign digit5       = digits_q[19:16];
    assign digit6       = digits_q[23:20];
    assign digit7       = digits_q[27:24];
    assign digit8       = digits_q[31:28];
    assign digit9       = digits_q[35:32];

endmodule

// File: tb/tb_score_bcd_digitizer.sv
// Randomized scoreboard bench: a decimal reference model queues expected digits on each
// accepted start; a negedge monitor pops and compares on every done pulse.
module tb_score_bcd_digitizer;

    typedef struct packed {
        logic [35:0] dig;
        logic [8:0]  vis;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startConv = 1'b0;
    logic [29:0] binValue = '0;
    logic        busy, done;
    logic [3:0]  digit1, digit2, digit3, digit4, digit5, digit6, digit7, digit8, digit9;
    logic [8:0]  digitVisible;

    int   checks = 0;
    int   failures = 0;
    int   rem = 0;
    logic done_exp = 1'b0;
    exp_t exp_q[$];
    exp_t shown = '{dig: 36'h0, vis: 9'h001};

    score_bcd_digitizer dut (
        .clk(clk), .resetN(resetN), .startConv(startConv), .binValue(binValue),
        .busy(busy), .done(done),
        .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4), .digit5(digit5),
        .digit6(digit6), .digit7(digit7), .digit8(digit8), .digit9(digit9),
        .digitVisible(digitVisible)
    );

    always #5 clk = ~clk;

    // Decimal reference: clamp, peel off base-10 digits, mask = number of significant digits.
    function automatic exp_t ref_model(input logic [29:0] v);
        exp_t r;
        longint unsigned n = longint'(v);
        longint unsigned t;
        int nd = 1;
        if (n > 64'd999999999) n = 64'd999999999;
        t = n;
        while (t >= 10) begin
            nd++;
            t = t / 10;
        end
        for (int i = 0; i < 9; i++) begin
            r.dig[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        r.vis = 9'((1 << nd) - 1);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of acceptance: after an accept the block ignores starts for 31 more edges.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rem      <= 0;
            done_exp <= 1'b0;
            exp_q.delete();
        end else begin
            done_exp <= (rem == 1);
            if (rem != 0) begin
                rem <= rem - 1;
            end else if (startConv === 1'b1) begin
                rem <= 31;
                exp_q.push_back(ref_model(binValue));
            end
        end
    end

    always @(negedge clk) begin
        logic [35:0] dig;
        logic        bad_nib;
        dig = {digit9, digit8, digit7, digit6, digit5, digit4, digit3, digit2, digit1};
        bad_nib = 1'b0;
        for (int i = 0; i < 9; i++) if (dig[4*i +: 4] > 4'd9) bad_nib = 1'b1;
        if (!resetN) begin
            shown = '{dig: 36'h0, vis: 9'h001};
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_digits", 64'(dig), 64'd0);
            chk("rst_vis", 64'(digitVisible), 64'h001);
        end else begin
            chk("busy", 64'(busy), 64'(rem != 0));
            chk("done", 64'(done), 64'(done_exp));
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
                end else begin
                    shown = exp_q.pop_front();
                    $display("conv done digits=%09h vis=%03h expected digits=%09h vis=%03h",
                             dig, digitVisible, shown.dig, shown.vis);
                end
            end
            chk("digits", 64'(dig), 64'(shown.dig));
            chk("vis", 64'(digitVisible), 64'(shown.vis));
            chk("nibble_range", 64'(bad_nib), 64'd0);
        end
    end

    task automatic convert(input logic [29:0] v);
        @(negedge clk);
        binValue  = v;
        startConv = 1'b1;
        @(negedge clk);
        startConv = 1'b0;
        binValue  = 30'($urandom);
        repeat (34) @(negedge clk);
    endtask

    function automatic logic [29:0] rand_value();
        case ($urandom_range(0, 3))
            0:       return 30'($urandom_range(0, 99));
            1:       return 30'($urandom);
            2:       return 30'($urandom_range(999999990, 1000000010));
            default: return 30'($urandom_range(0, 999999));
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        #2 resetN = 1'b1;
        repeat (2) @(negedge clk);

        convert(30'd0);
        convert(30'd1234);
        convert(30'd999999999);
        convert(30'h3FFFFFFF);
        convert(30'd1000000000);
        convert(30'd100000000);

        // Second start during conversion must be ignored
        @(negedge clk);
        binValue = 30'd1234; startConv = 1'b1;
        @(negedge clk);
        startConv = 1'b0;
        repeat (8) @(negedge clk);
        binValue = 30'd5678; startConv = 1'b1;
        @(negedge clk);
        startConv = 1'b0;
        repeat (30) @(negedge clk);

        // Reset in the middle of a conversion aborts it
        @(negedge clk);
        binValue = 30'd50; startConv = 1'b1;
        @(negedge clk);
        startConv = 1'b0;
        repeat (14) @(negedge clk);
        #2 resetN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 resetN = 1'b1;
        repeat (2) @(negedge clk);
        convert(30'd50);

        // Start held high: back-to-back accepts every 32 cycles
        @(negedge clk);
        binValue = 30'd7; startConv = 1'b1;
        @(negedge clk);
        binValue = 30'd80;
        repeat (70) @(negedge clk);
        startConv = 1'b0;
        repeat (34) @(negedge clk);

        for (int n = 0; n < 30; n++) begin
            int hold;
            hold = $urandom_range(1, 40);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                binValue  = rand_value();
                startConv = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            startConv = 1'b0;
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        repeat (35) @(negedge clk);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
